uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 36 +++
 rtl/baud_gen.sv | 37 +++
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state, parity and stop-bit definitions for the UART transmitter
package uart_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity mode encodings; 2'b11 also means no parity
  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // Stop-bit selection
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Smallest divisor the bit timer can honour
  localparam int MIN_DIV = 2;

  // True when the mode inserts a parity bit
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit from the XOR of the payload bits
  function automatic logic parity_value(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - restartable bit-period counter producing one tick per bit
module baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             at_end;

  // The divisor is already clamped to at least 2 by the caller
  assign at_end     = (cnt_q == (div_i - DIV_W'(1)));
  assign bit_tick_o = at_end & ~restart_i;

  // Count 0..div-1, wrapping on the tick or when the sequencer restarts the period
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart_i || at_end) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with runtime divisor, parity and stop-bit selection
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              TX
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              restart;
  logic              bit_tick;
  logic              done_c;
  logic              accept;

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign accept   = tx_valid & tx_ready;
  assign tx_done  = done_c;
  assign TX       = tx_q;

  baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk        (clk),
    .RST        (RST),
    .restart_i  (restart),
    .div_i      (div_q),
    .bit_tick_o (bit_tick)
  );

  // Next-state and next line level; TX is registered from the level of the upcoming bit
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    restart    = 1'b0;
    done_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        tx_d    = 1'b1;
        if (accept) begin
          shreg_d    = tx_data;
          div_d      = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
          par_en_d   = parity_enabled(cfg_parity);
          par_bit_d  = parity_value(cfg_parity, ^tx_data);
          stop2_d    = (cfg_stop2 == STOP_TWO);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
            tx_d      = shreg_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, captured frame parameters and the registered line
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= '0;
      div_q      <= DIV_W'(MIN_DIV);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with 8-bit and 9-bit instances
module tb_uart_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        RST;
  logic        tx_valid;
  logic        sel9;
  logic [8:0]  tx_data;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;

  logic        ready8, busy8, done8, tx8;
  logic        ready9, busy9, done9, tx9;
  logic        valid8, valid9;
  logic        s_ready, s_busy, s_done, s_tx;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign valid8  = tx_valid & ~sel9;
  assign valid9  = tx_valid & sel9;
  assign s_ready = sel9 ? ready9 : ready8;
  assign s_busy  = sel9 ? busy9  : busy8;
  assign s_done  = sel9 ? done9  : done8;
  assign s_tx    = sel9 ? tx9    : tx8;

  uart_tx #(.DATA_W(8), .DIV_W(16)) u_dut8 (
    .clk        (clk),
    .RST        (RST),
    .tx_valid   (valid8),
    .tx_ready   (ready8),
    .tx_data    (tx_data[7:0]),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx_busy    (busy8),
    .tx_done    (done8),
    .TX         (tx8)
  );

  uart_tx #(.DATA_W(9), .DIV_W(16)) u_dut9 (
    .clk        (clk),
    .RST        (RST),
    .tx_valid   (valid9),
    .tx_ready   (ready9),
    .tx_data    (tx_data),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx_busy    (busy9),
    .tx_done    (done9),
    .TX         (tx9)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one frame from an idle negedge and checks every cycle against the frame model.
  // With chain set, tx_valid stays high carrying the next frame's values.
  task automatic do_frame(input string tag, input int w, input logic [8:0] d,
                          input logic [15:0] div, input logic [1:0] par, input logic st2,
                          input bit chain, input logic [8:0] nd, input logic [15:0] ndiv,
                          input logic [1:0] npar, input logic nst2);
    logic exp_bits[$];
    logic px;
    int   de;
    int   len;
    sel9 = (w == 9);
    chk({tag, ".ready_pre"}, s_ready, 1);
    tx_valid = 1'b1; tx_data = d; cfg_div = div; cfg_parity = par; cfg_stop2 = st2;
    px = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      exp_bits.push_back(d[i]);
      px ^= d[i];
    end
    if (par == 2'b01) exp_bits.push_back(px);
    else if (par == 2'b10) exp_bits.push_back(~px);
    exp_bits.push_back(1'b1);
    if (st2) exp_bits.push_back(1'b1);
    de  = (div < 2) ? 2 : int'(div);
    len = de * exp_bits.size();
    @(posedge clk); #1;
    if (chain) begin
      tx_data = nd; cfg_div = ndiv; cfg_parity = npar; cfg_stop2 = nst2;
    end else begin
      tx_valid   = 1'b0;
      tx_data    = 9'($urandom);
      cfg_div    = 16'($urandom_range(0, 9));
      cfg_parity = 2'($urandom);
      cfg_stop2  = 1'($urandom);
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk({tag, ".tx"}, s_tx, exp_bits[(k - 1) / de]);
      chk({tag, ".done"}, s_done, (k == len));
      chk({tag, ".ready"}, s_ready, 0);
      chk({tag, ".busy"}, s_busy, 1);
      if (!chain && k == 2) tx_valid = 1'b1;
      if (!chain && k == 4) tx_valid = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".idle_ready"}, s_ready, 1);
    chk({tag, ".idle_tx"}, s_tx, 1);
    chk({tag, ".idle_done"}, s_done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] rd;
    RST = 1'b1; tx_valid = 1'b0; sel9 = 1'b0;
    tx_data = '0; cfg_div = 16'd4; cfg_parity = PAR_NONE; cfg_stop2 = STOP_ONE;

    repeat (3) @(negedge clk);
    chk("rst.tx8", tx8, 1);
    chk("rst.done8", done8, 0);
    chk("rst.ready8", ready8, 1);
    chk("rst.tx9", tx9, 1);
    chk("rst.busy9", busy9, 0);
    RST = 1'b0;
    @(negedge clk);
    chk("post_rst.ready8", ready8, 1);
    chk("post_rst.ready9", ready9, 1);

    do_frame("a5", 8, 9'h0A5, 16'd4, PAR_NONE, STOP_ONE, 0, '0, '0, '0, 0);
    do_frame("even07", 8, 9'h007, 16'd5, PAR_EVEN, STOP_ONE, 0, '0, '0, '0, 0);
    do_frame("odd07", 8, 9'h007, 16'd3, PAR_ODD, STOP_ONE, 0, '0, '0, '0, 0);
    do_frame("stop2", 8, 9'h0C3, 16'd3, PAR_NONE_ALT, STOP_TWO, 0, '0, '0, '0, 0);
    do_frame("div1", 8, 9'h05E, 16'd1, PAR_EVEN, STOP_ONE, 0, '0, '0, '0, 0);
    do_frame("div0", 8, 9'h081, 16'd0, PAR_NONE, STOP_TWO, 0, '0, '0, '0, 0);

    do_frame("b2b_a", 8, 9'h03C, 16'd3, PAR_EVEN, STOP_ONE, 1, 9'h05A, 16'd5, PAR_ODD, STOP_TWO);
    do_frame("b2b_b", 8, 9'h05A, 16'd5, PAR_ODD, STOP_TWO, 0, '0, '0, '0, 0);

    do_frame("w9_1ff", 9, 9'h1FF, 16'd3, PAR_ODD, STOP_ONE, 0, '0, '0, '0, 0);

    for (int n = 0; n < 8; n++) begin
      do_frame($sformatf("rnd%0d", n), ($urandom_range(0, 1) == 1) ? 9 : 8, 9'($urandom),
               16'($urandom_range(0, 6)), 2'($urandom), 1'($urandom), 0, '0, '0, '0, 0);
    end

    // Reset in the 5th data bit aborts the frame without a done pulse
    sel9 = 1'b0;
    rd = 9'($urandom);
    tx_valid = 1'b1; tx_data = rd; cfg_div = 16'd4; cfg_parity = PAR_NONE; cfg_stop2 = STOP_ONE;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      chk("abort.tx", s_tx, (k <= 4) ? 1'b0 : rd[(k - 5) / 4]);
    end
    RST = 1'b1;
    @(negedge clk);
    chk("abort.tx_next", s_tx, 1);
    chk("abort.done", s_done, 0);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort.ready", s_ready, 1);
      chk("abort.idle_tx", s_tx, 1);
      chk("abort.idle_done", s_done, 0);
    end

    do_frame("after_abort", 8, 9'h0F0, 16'd2, PAR_EVEN, STOP_TWO, 0, '0, '0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
